// File: rtl/actor_ctrl_pkg.sv
// Shared game definitions: movement/facing codes, map tile codes and the
// sprite transparency key, used by the player, monster and map blocks.
package actor_ctrl_pkg;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } move_state_e;

  typedef enum logic [2:0] {
    ROAD0  = 3'd0,
    ROAD1  = 3'd1,
    WALL   = 3'd2,
    STAIRS = 3'd3,
    WATER  = 3'd4,
    TREE   = 3'd5,
    DOOR   = 3'd6,
    LAVA   = 3'd7
  } tile_e;

  // Palette index treated as see-through when sprites are composited
  localparam logic [7:0] TRANSPARENT = 8'hE3;

  function automatic logic is_walkable(input logic [2:0] code);
    return (code == ROAD0) || (code == ROAD1) || (code == STAIRS);
  endfunction

endpackage

// File: rtl/actor_hit_detect.sv
// Counts live monsters standing on the actor's tile while collisions are enabled.
module actor_hit_detect #(
  parameter int N_MONSTER = 4,
  parameter int CNT_W     = $clog2(N_MONSTER + 1)
) (
  input  logic [10*N_MONSTER-1:0] monster_r,
  input  logic [10*N_MONSTER-1:0] monster_c,
  input  logic [N_MONSTER-1:0]    monster_alive,
  input  logic                    hit_en,
  input  logic [9:0]              tile_r,
  input  logic [9:0]              tile_c,
  output logic [CNT_W-1:0]        touch_cnt
);

  // Sum of per-monster tile matches
  always_comb begin
    touch_cnt = '0;
    for (int unsigned i = 0; i < N_MONSTER; i++) begin
      if (hit_en && monster_alive[i] &&
          monster_r[10*i +: 10] == tile_r &&
          monster_c[10*i +: 10] == tile_c)
        touch_cnt = touch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/actor_ctrl.sv
// Player actor: tile-stepped movement with pixel-smooth animation, HP with
// post-hit immunity, healing and teleport.
module actor_ctrl #(
  parameter int N_MONSTER     = 4,
  parameter int HP_FULL       = 5,
  parameter int HP_W          = 5,
  parameter int DAMAGE        = 1,
  parameter int HEAL          = 1,
  parameter int INVULN_CYCLES = 4096,
  parameter int SPRITE_LEN    = 32,
  parameter int WALK_DELAY    = 5,
  parameter int START_R       = 3,
  parameter int START_C       = 3
) (
  input  logic                    clk_13,
  input  logic                    rst_n,
  input  logic                    up_pressed,
  input  logic                    down_pressed,
  input  logic                    left_pressed,
  input  logic                    right_pressed,
  output logic [9:0]              dest_r,
  output logic [9:0]              dest_c,
  input  logic [2:0]              dest_type,
  input  logic                    respawn,
  input  logic [9:0]              spawn_r,
  input  logic [9:0]              spawn_c,
  input  logic [10*N_MONSTER-1:0] monster_r,
  input  logic [10*N_MONSTER-1:0] monster_c,
  input  logic [N_MONSTER-1:0]    monster_alive,
  input  logic                    hit_en,
  input  logic                    heal,
  output logic [9:0]              tile_r,
  output logic [9:0]              tile_c,
  output logic [9:0]              pix_v,
  output logic [9:0]              pix_h,
  output logic [2:0]              facing,
  output logic [2:0]              move_stat,
  output logic [1:0]              anim_frame,
  output logic [HP_W-1:0]         hp,
  output logic                    alive,
  output logic                    invuln,
  output logic                    hit_pulse
);

  import actor_ctrl_pkg::*;

  localparam int MOVE_LEN = SPRITE_LEN << WALK_DELAY;
  localparam int MCW      = $clog2(MOVE_LEN);
  localparam int IVW      = $clog2(INVULN_CYCLES + 1);
  localparam int CNT_W    = $clog2(N_MONSTER + 1);

  move_state_e       state, state_n, facing_q, facing_n, req_dir;
  logic [9:0]        tile_r_q, tile_c_q, tile_r_n, tile_c_n;
  logic [9:0]        pix_v_q, pix_h_q, pix_v_n, pix_h_n;
  logic [MCW-1:0]    move_cnt, move_cnt_n;
  logic [HP_W-1:0]   hp_q, hp_n;
  logic [IVW-1:0]    invuln_cnt, invuln_n;
  logic              hit_pulse_q, hit_pulse_n;
  logic [CNT_W-1:0]  touch_cnt;
  logic [31:0]       dmg, hp_ext;
  logic              hit_w;

  actor_hit_detect #(
    .N_MONSTER (N_MONSTER),
    .CNT_W     (CNT_W)
  ) u_hit_detect (
    .monster_r     (monster_r),
    .monster_c     (monster_c),
    .monster_alive (monster_alive),
    .hit_en        (hit_en),
    .tile_r        (tile_r_q),
    .tile_c        (tile_c_q),
    .touch_cnt     (touch_cnt)
  );

  assign tile_r    = tile_r_q;
  assign tile_c    = tile_c_q;
  assign pix_v     = pix_v_q;
  assign pix_h     = pix_h_q;
  assign facing    = facing_q;
  assign move_stat = state;
  assign hp        = hp_q;
  assign alive     = (hp_q != '0);
  assign invuln    = (invuln_cnt != '0);
  assign hit_pulse = hit_pulse_q;

  // Direction request decode (up > down > left > right) and adjacent-tile query
  always_comb begin
    req_dir = STOP;
    if (state == STOP && alive) begin
      if (up_pressed)         req_dir = UP;
      else if (down_pressed)  req_dir = DOWN;
      else if (left_pressed)  req_dir = LEFT;
      else if (right_pressed) req_dir = RIGHT;
    end
    dest_r = tile_r_q;
    dest_c = tile_c_q;
    case (req_dir)
      UP:      dest_r = tile_r_q - 10'd1;
      DOWN:    dest_r = tile_r_q + 10'd1;
      LEFT:    dest_c = tile_c_q - 10'd1;
      RIGHT:   dest_c = tile_c_q + 10'd1;
      default: ;
    endcase
  end

  // Walk cycle: high half of the move count shows frame 2, low half frame 1
  always_comb begin
    if (state == STOP)          anim_frame = 2'd0;
    else if (move_cnt[MCW-1])   anim_frame = 2'd2;
    else                        anim_frame = 2'd1;
  end

  // Move FSM next state and position datapath; respawn overrides everything
  always_comb begin
    state_n    = state;
    facing_n   = facing_q;
    tile_r_n   = tile_r_q;
    tile_c_n   = tile_c_q;
    pix_v_n    = pix_v_q;
    pix_h_n    = pix_h_q;
    move_cnt_n = move_cnt;
    if (respawn) begin
      state_n    = STOP;
      tile_r_n   = spawn_r;
      tile_c_n   = spawn_c;
      pix_v_n    = 10'(spawn_r * SPRITE_LEN);
      pix_h_n    = 10'(spawn_c * SPRITE_LEN);
      move_cnt_n = '0;
    end else if (state == STOP) begin
      if (req_dir != STOP) begin
        facing_n = req_dir;
        if (is_walkable(dest_type)) begin
          state_n    = req_dir;
          tile_r_n   = dest_r;
          tile_c_n   = dest_c;
          move_cnt_n = MCW'(MOVE_LEN - 1);
        end
      end
    end else begin
      move_cnt_n = move_cnt - MCW'(1);
      if (move_cnt[WALK_DELAY-1:0] == '0) begin
        case (state)
          UP:      pix_v_n = pix_v_q - 10'd1;
          DOWN:    pix_v_n = pix_v_q + 10'd1;
          LEFT:    pix_h_n = pix_h_q - 10'd1;
          RIGHT:   pix_h_n = pix_h_q + 10'd1;
          default: ;
        endcase
      end
      // The final step lands on the tile origin exactly
      if (move_cnt == '0) begin
        state_n    = STOP;
        move_cnt_n = '0;
        pix_v_n    = 10'(tile_r_q * SPRITE_LEN);
        pix_h_n    = 10'(tile_c_q * SPRITE_LEN);
      end
    end
  end

  // HP update: saturating damage first, then heal capped at full
  always_comb begin
    dmg         = 32'(DAMAGE) * 32'(touch_cnt);
    hit_w       = (touch_cnt != '0) && (invuln_cnt == '0);
    hp_ext      = 32'(hp_q);
    hit_pulse_n = 1'b0;
    invuln_n    = invuln_cnt;
    if (invuln_cnt != '0)
      invuln_n = invuln_cnt - IVW'(1);
    if (hit_w) begin
      hp_ext      = (hp_ext > dmg) ? (hp_ext - dmg) : 32'd0;
      hit_pulse_n = 1'b1;
      invuln_n    = IVW'(INVULN_CYCLES);
    end
    if (heal && hp_q != '0) begin
      hp_ext = hp_ext + 32'(HEAL);
      if (hp_ext > 32'(HP_FULL))
        hp_ext = 32'(HP_FULL);
    end
    hp_n = HP_W'(hp_ext);
  end

  // State and datapath registers
  always_ff @(posedge clk_13 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= STOP;
      facing_q    <= DOWN;
      tile_r_q    <= 10'(START_R);
      tile_c_q    <= 10'(START_C);
      pix_v_q     <= 10'(START_R * SPRITE_LEN);
      pix_h_q     <= 10'(START_C * SPRITE_LEN);
      move_cnt    <= '0;
      hp_q        <= HP_W'(HP_FULL);
      invuln_cnt  <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state       <= state_n;
      facing_q    <= facing_n;
      tile_r_q    <= tile_r_n;
      tile_c_q    <= tile_c_n;
      pix_v_q     <= pix_v_n;
      pix_h_q     <= pix_h_n;
      move_cnt    <= move_cnt_n;
      hp_q        <= hp_n;
      invuln_cnt  <= invuln_n;
      hit_pulse_q <= hit_pulse_n;
    end
  end

endmodule

// File: doc/actor_ctrl.md
ACTOR_CTRL -- requirements
Module: actor_ctrl

Interface
REQ-001 SHALL have parameters: N_MONSTER=4 (monsters checked); HP_FULL=5 (reset HP); HP_W=5 (HP width); DAMAGE=1 (HP lost per touching monster); HEAL=1 (HP per heal pulse); INVULN_CYCLES=4096 (post-hit immunity); SPRITE_LEN=32 (tile pixels); WALK_DELAY=5 (log2 cycles per pixel step, >=1); START_R=3, START_C=3 (reset tile).
REQ-002 SHALL have ports: clk_13 in 1 (sole clock); rst_n in 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports: up_pressed, down_pressed, left_pressed, right_pressed in 1 each (debounced direction requests).
REQ-004 SHALL have ports: dest_r, dest_c out 10 each (tile being queried); dest_type in 3 (tile code returned combinationally, same cycle).
REQ-005 SHALL have ports: respawn in 1 (teleport pulse); spawn_r, spawn_c in 10 each (teleport target).
REQ-006 SHALL have ports: monster_r, monster_c in 10*N_MONSTER each (packed, monster i at bits [10i+9:10i]); monster_alive in N_MONSTER; hit_en in 1 (map gating for collisions); heal in 1 (heal pulse).
REQ-007 SHALL have ports: tile_r, tile_c out 10; pix_v, pix_h out 10 (sprite top-left on VGA); facing out 3; move_stat out 3; anim_frame out 2; hp out HP_W; alive out 1; invuln out 1; hit_pulse out 1.

Function
REQ-008 Move FSM SHALL have states STOP, UP, DOWN, LEFT, RIGHT; tile codes ROAD0, ROAD1, STAIRS are walkable, all others are blocking.
REQ-009 In STOP with alive=1, the first asserted direction in priority order up>down>left>right SHALL drive dest_r/dest_c to the adjacent tile and set facing; otherwise dest = tile.
REQ-010 If dest is walkable: next cycle SHALL enter the direction state, tile_r/c := dest (exactly once, at move start), move_cnt := SPRITE_LEN*2^WALK_DELAY-1; if blocking: SHALL stay STOP, facing updated, tile unchanged.
REQ-011 In a move state, pix_v/pix_h SHALL step 1 pixel toward dest in every cycle where move_cnt[WALK_DELAY-1:0]==0; move_cnt decrements each cycle.
REQ-012 At move_cnt==0 the FSM SHALL return to STOP with pix = tile*SPRITE_LEN exactly; one move therefore takes SPRITE_LEN*2^WALK_DELAY+1 cycles from the request edge.
REQ-013 Direction inputs SHALL be ignored outside STOP.
REQ-014 anim_frame SHALL be 0 in STOP, 2 while the move_cnt MSB=1, and 1 otherwise.
REQ-015 Monster i SHALL be touching when hit_en=1, monster_alive[i]=1 and {monster_r_i,monster_c_i}=={tile_r,tile_c}.
REQ-016 If any monster is touching and invuln=0: hp SHALL drop by DAMAGE*(number touching), saturating at 0; hit_pulse=1 for one cycle; invuln counter := INVULN_CYCLES.
REQ-017 While the invuln counter is nonzero, invuln=1, touches SHALL cause no damage, and the counter decrements each cycle.
REQ-018 A heal pulse SHALL add HEAL saturating at HP_FULL; on a simultaneous hit and heal, hp := min(HP_FULL, max(0, hp-damage)+HEAL).
REQ-019 alive = (hp!=0); once hp reaches 0, heal SHALL be ignored, no new moves may start, and an in-progress move completes.
REQ-020 respawn SHALL take priority over all moves: next cycle tile := spawn, pix := spawn*SPRITE_LEN, FSM := STOP, move_cnt := 0; hp, facing and invuln remain unchanged.
REQ-021 All position arithmetic SHALL be 10-bit unsigned; the caller guarantees in-map targets.

Reset
REQ-022 On rst_n=0 (asynchronous): tile=(START_R,START_C); pix=tile*SPRITE_LEN; FSM=STOP; facing=DOWN; move_cnt=0; hp=HP_FULL; invuln counter=0; hit_pulse=0.
REQ-023 Reset asserted mid-move SHALL abandon the move immediately with no partial position retained.

Structure
REQ-024 Move-state codes, tile codes and TRANSPARENT SHALL live in the shared game package or header, used by player, monsters and map.
REQ-025 Collision counting SHALL be a sub-module actor_hit_detect (parametrised N_MONSTER, combinational touch count); all other logic is in actor_ctrl.

Verification
REQ-026 Reset, then right_pressed pulse with dest_type=ROAD0 -> tile_c=4 next cycle; pix_h goes 96->128 in 32 steps; STOP after 1025 cycles; anim_frame sequence 2 then 1 then 0.
REQ-027 up_pressed with dest_type=WALL -> FSM stays STOP, facing=UP, tile and pix unchanged.
REQ-028 Monsters 0 and 2 alive at (3,3), hit_en=1 -> hp 5->3, one hit_pulse; monsters held there for 4096 cycles -> no further loss; next cycle -> hp=1.
REQ-029 hp=1 with hit and heal in the same cycle -> hp=1; then hp=0 -> heal and direction pulses ignored, alive=0.
REQ-030 Respawn to (7,9) mid-move -> next cycle STOP, tile=(7,9), pix=(224,288); a following move starts normally.
REQ-031 rst_n pulsed low mid-move with hp=2 -> outputs immediately at reset values (tile (3,3), hp=5).
